usb_in_txn_ctrl: RTL

- Host-side sequencer for USB IN transactions; sits above the packet encoder (TX) and the CRC-checking packet decoder (RX).
- Per transaction: commands the encoder to send an IN token, opens the decoder window, and waits for a DATA0/DATA1 reply with a timeout.
- Judges the reply (valid, PID, data toggle), sends ACK when required, retries on NAK/error/timeout, and reports final status to the client.

---
 rtl/usb_in_txn_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/usb_in_txn_ctrl.sv
// usb_in_txn_ctrl: host-side sequencer for USB IN transactions.
// Each transaction sends an IN token through the packet encoder and opens
// the decoder window. It then waits a bounded time for a DATA0/DATA1 reply,
// ACKs an accepted reply and retries on NAK, error or timeout. Final status
// is reported to the client.
// Ports:
//   clk, rst_b              clock; asynchronous active-low reset
//   txn_start/addr/endp     client request (accepted only in IDLE)
//   toggle_clr              force expected toggle to DATA0 (IDLE only)
//   send_req/pid, tok_*     encoder command, held until send_done
//   send_done               encoder completion pulse
//   dec_en                  decoder window (WAIT_DATA only)
//   pkt_avail/valid/pid/data decoder result
//   busy, txn_done, txn_status, data_out, exp_toggle  client status
module usb_in_txn_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 8,
  parameter int unsigned DATA_W         = 64
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              txn_start,
  input  logic [6:0]        txn_addr,
  input  logic [3:0]        txn_endp,
  input  logic              toggle_clr,
  output logic              send_req,
  output logic [3:0]        send_pid,
  output logic [6:0]        tok_addr,
  output logic [3:0]        tok_endp,
  input  logic              send_done,
  output logic              dec_en,
  input  logic              pkt_avail,
  input  logic              pkt_valid,
  input  logic [3:0]        pkt_pid,
  input  logic [DATA_W-1:0] pkt_data,
  output logic              busy,
  output logic              txn_done,
  output logic [1:0]        txn_status,
  output logic [DATA_W-1:0] data_out,
  output logic              exp_toggle
);

  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_NAKL  = 2'b10;
  localparam logic [1:0] ST_ERRL  = 2'b11;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, SEND_TOK, WAIT_DATA, SEND_ACK, DONE} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] tcnt;
  logic          ack_retry;   // ACK in flight answers a wrong-toggle packet
  logic          start, accept, mistog, retry_inc, tcnt_clr;
  logic          do_retry, kind_nak;
  logic [1:0]    fin_status;
  logic [3:0]    pid_exp, pid_other;

  assign pid_exp   = exp_toggle ? PID_DATA1 : PID_DATA0;
  assign pid_other = exp_toggle ? PID_DATA0 : PID_DATA1;

  assign send_req = (state == SEND_TOK) || (state == SEND_ACK);
  assign send_pid = (state == SEND_ACK) ? PID_ACK : PID_IN;
  assign dec_en   = (state == WAIT_DATA);
  assign busy     = (state != IDLE);
  assign txn_done = (state == DONE);

  always_comb begin
    state_nxt  = state;
    fin_status = ST_OK;
    start      = 1'b0;
    accept     = 1'b0;
    mistog     = 1'b0;
    retry_inc  = 1'b0;
    tcnt_clr   = 1'b0;
    do_retry   = 1'b0;
    kind_nak   = 1'b0;
    case (state)
      IDLE: if (txn_start) begin
        start     = 1'b1;
        state_nxt = SEND_TOK;
      end
      SEND_TOK: if (send_done) begin
        tcnt_clr  = 1'b1;
        state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        // A packet arriving in the expiry cycle takes priority over timeout.
        if (pkt_avail) begin
          if (pkt_valid && pkt_pid == pid_exp) begin
            accept    = 1'b1;
            state_nxt = SEND_ACK;
          end else if (pkt_valid && pkt_pid == pid_other) begin
            mistog    = 1'b1;
            state_nxt = SEND_ACK;
          end else if (pkt_valid && pkt_pid == PID_NAK) begin
            do_retry  = 1'b1;
            kind_nak  = 1'b1;
          end else if (pkt_valid && pkt_pid == PID_STALL) begin
            fin_status = ST_STALL;
            state_nxt  = DONE;
          end else begin
            do_retry = 1'b1;
          end
        end else if (tcnt == T_LAST) begin
          do_retry = 1'b1;
        end
      end
      SEND_ACK: if (send_done) begin
        if (ack_retry) do_retry = 1'b1;
        else           state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (do_retry) begin
      if (retry_cnt < R_MAX) begin
        retry_inc = 1'b1;
        state_nxt = SEND_TOK;
      end else begin
        fin_status = kind_nak ? ST_NAKL : ST_ERRL;
        state_nxt  = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      tcnt       <= '0;
      ack_retry  <= 1'b0;
      tok_addr   <= '0;
      tok_endp   <= '0;
      txn_status <= ST_OK;
      data_out   <= '0;
      exp_toggle <= 1'b0;
    end else begin
      state <= state_nxt;
      // Clear precedes a coincident start; start never touches the toggle.
      if (state == IDLE && toggle_clr) exp_toggle <= 1'b0;
      if (start) begin
        tok_addr  <= txn_addr;
        tok_endp  <= txn_endp;
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (tcnt_clr)                              tcnt <= '0;
      else if (state == WAIT_DATA && tcnt != T_MAX) tcnt <= tcnt + 1'b1;
      if (accept) begin
        data_out   <= pkt_data;
        exp_toggle <= ~exp_toggle;
      end
      if (state == WAIT_DATA && state_nxt == SEND_ACK) ack_retry <= mistog;
      // Status is loaded on entry so it is valid alongside txn_done.
      if (state != DONE && state_nxt == DONE) txn_status <= fin_status;
    end
  end

endmodule
